// File: rtl/spek_mem_pkg.sv
// Shared types and geometry helpers for the miss/refill engine.
package spek_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int unsigned beats(input int unsigned line_bits,
                                        input int unsigned bus_bits);
    return line_bits / bus_bits;
  endfunction

  function automatic int unsigned bbytes(input int unsigned bus_bits);
    return bus_bits / 8;
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0]   addr,
                                             input int unsigned offset_bits);
    return addr & ~((64'd1 << offset_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_refill_ctl_if.sv
// Cache-side request/response and memory-bus beat signals of the refill engine.
interface mem_refill_ctl_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned LINE_BITS = 512,
  parameter int unsigned BUS_BITS  = 64
);
  logic                 i_miss;
  logic [ADDR_BITS-1:0] i_miss_addr;
  logic                 i_evict;
  logic [ADDR_BITS-1:0] i_evict_addr;
  logic [LINE_BITS-1:0] i_evict_data;
  logic                 o_stall;
  logic [LINE_BITS-1:0] o_line;
  logic                 o_line_valid;
  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [ADDR_BITS-1:0] o_mem_addr;
  logic [BUS_BITS-1:0]  o_mem_wdata;
  logic                 i_mem_ack;
  logic [BUS_BITS-1:0]  i_mem_rdata;

  modport slave (
    input  i_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    input  i_mem_ack, i_mem_rdata,
    output o_stall, o_line, o_line_valid,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    output i_mem_ack, i_mem_rdata,
    input  o_stall, o_line, o_line_valid,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/line_buffer.sv
// One cache line of storage: whole-line load, beat-indexed write and beat-indexed read.
module line_buffer
  import spek_mem_pkg::*;
#(
  parameter  int unsigned LINE_BITS = 512,
  parameter  int unsigned BUS_BITS  = 64,
  localparam int unsigned IDX_W     = $clog2(beats(LINE_BITS, BUS_BITS))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [LINE_BITS-1:0] i_load_data,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_widx,
  input  logic [BUS_BITS-1:0]  i_wdata,
  input  logic [IDX_W-1:0]     i_ridx,
  output logic [BUS_BITS-1:0]  o_rdata,
  output logic [LINE_BITS-1:0] o_line
);

  logic [LINE_BITS-1:0] r_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_load_data;
    end else if (i_we) begin
      r_line[i_widx*BUS_BITS +: BUS_BITS] <= i_wdata;
    end
  end

  assign o_rdata = r_line[i_ridx*BUS_BITS +: BUS_BITS];
  assign o_line  = r_line;

endmodule

// File: rtl/mem_refill_ctl.sv
// Miss/refill engine: optional dirty-victim write-back, then a beat-wise line fetch
// (optionally critical-word-first) returned to the cache as a one-cycle valid pulse.
module mem_refill_ctl
  import spek_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned LINE_BITS   = 512,
  parameter int unsigned BUS_BITS    = 64,
  parameter int unsigned OFFSET_BITS = 6,
  parameter bit          CWF         = 1'b0
) (
  input logic            clk,
  input logic            rst,
  mem_refill_ctl_if.slave bus
);

  localparam int unsigned BEATS = beats(LINE_BITS, BUS_BITS);
  localparam int unsigned BOFF  = $clog2(bbytes(BUS_BITS));
  localparam int unsigned IDX_W = $clog2(BEATS);

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  localparam idx_t LAST = idx_t'(BEATS - 1);

  function automatic addr_t align(input addr_t a);
    return addr_t'(line_align(64'(a), OFFSET_BITS));
  endfunction

  function automatic addr_t beat_addr(input addr_t base, input idx_t idx);
    return base | (addr_t'(idx) << BOFF);
  endfunction

  state_t              r_state;
  idx_t                r_beat;
  idx_t                r_rd_start;
  addr_t               r_miss_base;
  addr_t               r_ev_base;
  logic                r_req;
  logic                r_we;
  logic                r_valid;
  addr_t               r_addr;
  logic [BUS_BITS-1:0] r_wdata;

  logic                 w_ack;
  idx_t                 w_next;
  idx_t                 w_in_start;
  addr_t                w_miss_base;
  addr_t                w_ev_base;
  logic                 w_buf_load;
  logic                 w_buf_we;
  logic [BUS_BITS-1:0]  w_buf_rdata;
  logic [LINE_BITS-1:0] w_line;

  assign w_ack       = r_req & bus.i_mem_ack;
  assign w_next      = r_beat + idx_t'(1);
  assign w_in_start  = CWF ? bus.i_miss_addr[OFFSET_BITS-1:BOFF] : '0;
  assign w_miss_base = align(bus.i_miss_addr);
  assign w_ev_base   = align(bus.i_evict_addr);
  assign w_buf_load  = (r_state == IDLE) & bus.i_miss & bus.i_evict;
  assign w_buf_we    = (r_state == RD) & w_ack;

  // The victim is loaded whole and drained beat by beat; refill beats then
  // overwrite every slot, so one buffer serves both lines.
  line_buffer #(
    .LINE_BITS (LINE_BITS),
    .BUS_BITS  (BUS_BITS)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_buf_load),
    .i_load_data (bus.i_evict_data),
    .i_we        (w_buf_we),
    .i_widx      (r_beat),
    .i_wdata     (bus.i_mem_rdata),
    .i_ridx      (w_next),
    .o_rdata     (w_buf_rdata),
    .o_line      (w_line)
  );

  // Beat outputs are registered, so the first beat is set up on the edge that leaves IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_rd_start  <= '0;
      r_miss_base <= '0;
      r_ev_base   <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (bus.i_miss) begin
            r_miss_base <= w_miss_base;
            r_rd_start  <= w_in_start;
            r_req       <= 1'b1;
            if (bus.i_evict) begin
              r_state   <= WB;
              r_ev_base <= w_ev_base;
              r_beat    <= '0;
              r_we      <= 1'b1;
              r_addr    <= w_ev_base;
              r_wdata   <= bus.i_evict_data[BUS_BITS-1:0];
            end else begin
              r_state <= RD;
              r_beat  <= w_in_start;
              r_we    <= 1'b0;
              r_addr  <= beat_addr(w_miss_base, w_in_start);
            end
          end
        end
        WB: begin
          if (w_ack) begin
            if (r_beat == LAST) begin
              r_state <= RD;
              r_beat  <= r_rd_start;
              r_we    <= 1'b0;
              r_addr  <= beat_addr(r_miss_base, r_rd_start);
              r_wdata <= '0;
            end else begin
              r_beat  <= w_next;
              r_addr  <= beat_addr(r_ev_base, w_next);
              r_wdata <= w_buf_rdata;
            end
          end
        end
        RD: begin
          if (w_ack) begin
            // Wrapping back onto the start index means every slot has been filled.
            if (w_next == r_rd_start) begin
              r_state <= DONE;
              r_beat  <= '0;
              r_req   <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_beat <= w_next;
              r_addr <= beat_addr(r_miss_base, w_next);
            end
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_stall      = (r_state != IDLE) | bus.i_miss;
  assign bus.o_line       = w_line;
  assign bus.o_line_valid = r_valid;
  assign bus.o_mem_req    = r_req;
  assign bus.o_mem_we     = r_we;
  assign bus.o_mem_addr   = r_addr;
  assign bus.o_mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_refill_ctl.sv
// Directed bench for mem_refill_ctl: one in-order instance and one critical-word-first instance.
module tb_mem_refill_ctl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_refill_ctl_if #(.ADDR_BITS(32), .LINE_BITS(512), .BUS_BITS(64)) bus0 ();
  mem_refill_ctl_if #(.ADDR_BITS(32), .LINE_BITS(512), .BUS_BITS(64)) bus1 ();

  mem_refill_ctl #(
    .ADDR_BITS(32), .LINE_BITS(512), .BUS_BITS(64), .OFFSET_BITS(6), .CWF(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  mem_refill_ctl #(
    .ADDR_BITS(32), .LINE_BITS(512), .BUS_BITS(64), .OFFSET_BITS(6), .CWF(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;
  bit ack_rand = 1'b0;
  int hs0 = 0;

  logic        p_hold;
  logic [31:0] p_addr;
  logic [63:0] p_wdata;
  logic        p_we;

  logic [31:0] cwf_addr [8] = '{32'h1230, 32'h1238, 32'h1200, 32'h1208,
                                32'h1210, 32'h1218, 32'h1220, 32'h1228};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory returns data derived from the beat address.
  function automatic logic [63:0] rd_pat(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  function automatic logic [511:0] exp_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = rd_pat(base + 32'(k * 8));
    return l;
  endfunction

  // Memory responder and hold-stability monitor.
  initial begin
    bus0.i_mem_ack   = 1'b0;
    bus0.i_mem_rdata = '0;
    bus1.i_mem_ack   = 1'b0;
    bus1.i_mem_rdata = '0;
    p_hold  = 1'b0;
    p_addr  = '0;
    p_wdata = '0;
    p_we    = 1'b0;
    forever begin
      @(negedge clk);
      if (p_hold) begin
        chk("hold_req",   bus0.o_mem_req,   1'b1);
        chk("hold_addr",  bus0.o_mem_addr,  p_addr);
        chk("hold_wdata", bus0.o_mem_wdata, p_wdata);
        chk("hold_we",    bus0.o_mem_we,    p_we);
      end
      bus0.i_mem_ack   = ack_rand ? ($urandom_range(99, 0) < 30) : 1'b1;
      bus0.i_mem_rdata = rd_pat(bus0.o_mem_addr);
      bus1.i_mem_ack   = 1'b1;
      bus1.i_mem_rdata = rd_pat(bus1.o_mem_addr);
      if (bus0.o_mem_req && bus0.i_mem_ack) hs0++;
      p_hold  = bus0.o_mem_req && !bus0.i_mem_ack;
      p_addr  = bus0.o_mem_addr;
      p_wdata = bus0.o_mem_wdata;
      p_we    = bus0.o_mem_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bus0.i_miss = 1'b0; bus0.i_miss_addr = '0; bus0.i_evict = 1'b0;
    bus0.i_evict_addr = '0; bus0.i_evict_data = '0;
    bus1.i_miss = 1'b0; bus1.i_miss_addr = '0; bus1.i_evict = 1'b0;
    bus1.i_evict_addr = '0; bus1.i_evict_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req",   bus0.o_mem_req,    1'b0);
    chk("rst_we",    bus0.o_mem_we,     1'b0);
    chk("rst_valid", bus0.o_line_valid, 1'b0);
    chk("rst_addr",  bus0.o_mem_addr,   32'h0);
    chk("rst_wdata", bus0.o_mem_wdata,  64'h0);
    chk("rst_line",  bus0.o_line,       512'h0);
    chk("rst_stall", bus0.o_stall,      1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Clean miss, in order, ack always high
    bus0.i_miss_addr = 32'h0000_1234;
    bus0.i_miss = 1'b1;
    #1 chk("a_stall_idle", bus0.o_stall, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("a_req",   bus0.o_mem_req,    1'b1);
      chk("a_we",    bus0.o_mem_we,     1'b0);
      chk("a_addr",  bus0.o_mem_addr,   32'h1200 + 32'((c - 1) * 8));
      chk("a_valid", bus0.o_line_valid, 1'b0);
    end
    @(negedge clk);
    chk("a_valid9",  bus0.o_line_valid, 1'b1);
    chk("a_line_lo", bus0.o_line[63:0], 64'hDEADACEF_00001200);
    chk("a_line",    bus0.o_line,       exp_line(32'h1200));
    chk("a_req_off", bus0.o_mem_req,    1'b0);
    chk("a_stall9",  bus0.o_stall,      1'b1);
    bus0.i_miss = 1'b0;
    @(negedge clk);
    chk("a_valid_off", bus0.o_line_valid, 1'b0);
    chk("a_stall_off", bus0.o_stall,      1'b0);
    chk("a_req_idle",  bus0.o_mem_req,    1'b0);

    // Dirty miss: write back victim, then refill
    for (int i = 0; i < 8; i++) bus0.i_evict_data[i*64 +: 64] = 64'(i * 17);
    bus0.i_evict_addr = 32'h0000_4000;
    bus0.i_evict = 1'b1;
    bus0.i_miss_addr = 32'h0000_8048;
    bus0.i_miss = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("b_stall", bus0.o_stall,      1'b1);
      chk("b_req",   bus0.o_mem_req,    1'b1);
      chk("b_valid", bus0.o_line_valid, 1'b0);
      if (c <= 8) begin
        chk("b_wb_we",    bus0.o_mem_we,    1'b1);
        chk("b_wb_addr",  bus0.o_mem_addr,  32'h4000 + 32'((c - 1) * 8));
        chk("b_wb_wdata", bus0.o_mem_wdata, 64'((c - 1) * 17));
      end else begin
        chk("b_rd_we",   bus0.o_mem_we,   1'b0);
        chk("b_rd_addr", bus0.o_mem_addr, 32'h8040 + 32'((c - 9) * 8));
      end
    end
    @(negedge clk);
    chk("b_valid17", bus0.o_line_valid, 1'b1);
    chk("b_line",    bus0.o_line,       exp_line(32'h8040));
    bus0.i_miss = 1'b0;
    bus0.i_evict = 1'b0;
    @(negedge clk);
    chk("b_valid_off", bus0.o_line_valid, 1'b0);

    // Critical-word-first on the second instance, crit = 6
    bus1.i_miss_addr = 32'h0000_1230;
    bus1.i_miss = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("c_req",  bus1.o_mem_req,  1'b1);
      chk("c_addr", bus1.o_mem_addr, cwf_addr[c]);
    end
    @(negedge clk);
    chk("c_valid",  bus1.o_line_valid,   1'b1);
    chk("c_beat6",  bus1.o_line[447:384], 64'hDEADACDF_00001230);
    chk("c_beat0",  bus1.o_line[63:0],    64'hDEADACEF_00001200);
    chk("c_line",   bus1.o_line,          exp_line(32'h1200));
    bus1.i_miss = 1'b0;
    @(negedge clk);
    chk("c_valid_off", bus1.o_line_valid, 1'b0);

    // Random ack backpressure: same line as the unthrottled run
    ack_rand = 1'b1;
    hs0 = 0;
    bus0.i_miss_addr = 32'h0000_1234;
    bus0.i_miss = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (bus0.o_line_valid) got = 1'b1;
    end
    chk("d_done",  got,         1'b1);
    chk("d_line",  bus0.o_line, exp_line(32'h1200));
    chk("d_beats", hs0,         8);
    bus0.i_miss = 1'b0;
    ack_rand = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the read phase, at beat 3
    bus0.i_miss_addr = 32'h0000_1234;
    bus0.i_miss = 1'b1;
    repeat (4) @(negedge clk);
    chk("e_addr_b3", bus0.o_mem_addr, 32'h1218);
    #2 rst = 1'b0;
    #1;
    chk("e_req_async", bus0.o_mem_req,    1'b0);
    chk("e_valid",     bus0.o_line_valid, 1'b0);
    chk("e_line",      bus0.o_line,       512'h0);
    chk("e_addr",      bus0.o_mem_addr,   32'h0);
    bus0.i_miss = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("e_quiet_valid", bus0.o_line_valid, 1'b0);
      chk("e_quiet_req",   bus0.o_mem_req,    1'b0);
    end
    bus0.i_miss_addr = 32'h0000_1234;
    bus0.i_miss = 1'b1;
    repeat (8) @(negedge clk);
    chk("e_b7_addr", bus0.o_mem_addr, 32'h1238);
    @(negedge clk);
    chk("e_valid9", bus0.o_line_valid, 1'b1);
    chk("e_line9",  bus0.o_line,       exp_line(32'h1200));
    bus0.i_miss = 1'b0;
    @(negedge clk);

    // Miss held through DONE: exactly one refill
    bus0.i_miss_addr = 32'h0000_2000;
    bus0.i_miss = 1'b1;
    repeat (9) @(negedge clk);
    chk("f_valid9", bus0.o_line_valid, 1'b1);
    chk("f_line",   bus0.o_line,       exp_line(32'h2000));
    @(negedge clk);
    chk("f_valid10", bus0.o_line_valid, 1'b0);
    chk("f_req10",   bus0.o_mem_req,    1'b0);
    chk("f_stall10", bus0.o_stall,      1'b1);
    bus0.i_miss = 1'b0;
    #1 chk("f_stall_drop", bus0.o_stall, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("f_no_req",   bus0.o_mem_req,    1'b0);
      chk("f_no_stall", bus0.o_stall,      1'b0);
      chk("f_no_valid", bus0.o_line_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
